// File: rtl/riscv_fetch_pc_sequencer_if.sv
// Fetch-side bus between the PC sequencer, the jump predictor, program memory and execute resolution.
// The master modport is the sequencer; the slave modport is its environment.
interface riscv_fetch_pc_sequencer_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4
);
    logic                       enable;
    logic                       i_stall;
    logic [ADDR_WIDTH-1:0]      o_pm_pc;
    logic                       i_inject;
    logic [ADDR_WIDTH-1:0]      i_inject_addr;
    logic                       o_fetch_valid;
    logic [ADDR_WIDTH-1:0]      o_fetch_pred_next;
    logic                       o_fetch_predicted;
    logic                       i_resolve_valid;
    logic                       i_resolve_taken;
    logic [ADDR_WIDTH-1:0]      i_resolve_target;
    logic                       o_flush;
    logic                       o_resolve_err;
    logic [$clog2(DEPTH):0]     o_pending;
    logic [31:0]                o_mispredict_count;

    modport master (
        input  enable, i_stall, i_inject, i_inject_addr,
        input  i_resolve_valid, i_resolve_taken, i_resolve_target,
        output o_pm_pc, o_fetch_valid, o_fetch_pred_next, o_fetch_predicted,
        output o_flush, o_resolve_err, o_pending, o_mispredict_count
    );

    modport slave (
        output enable, i_stall, i_inject, i_inject_addr,
        output i_resolve_valid, i_resolve_taken, i_resolve_target,
        input  o_pm_pc, o_fetch_valid, o_fetch_pred_next, o_fetch_predicted,
        input  o_flush, o_resolve_err, o_pending, o_mispredict_count
    );
endinterface

// File: rtl/riscv_fetch_pc_sequencer.sv
// Fetch PC generator: picks the next PC from the predictor answer, tracks predicted successors
// in an in-order FIFO and redirects/flushes when execute resolves an entry differently.
module riscv_fetch_pc_sequencer #(
    parameter int                    ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    DEPTH       = 4,
    parameter int                    INSTR_BYTES = 4
) (
    input logic                          clk,
    input logic                          reset,
    riscv_fetch_pc_sequencer_if.master   bus
);
    localparam int                    PTR_W      = $clog2(DEPTH);
    localparam int                    CNT_W      = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pred [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  flush_q;
    logic                  err_q;
    logic [31:0]           mispredicts;

    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  flush_now;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_pred;
    logic [ADDR_WIDTH-1:0] actual;
    logic [ADDR_WIDTH-1:0] next_pc;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign head_pc   = fifo_pc[head];
    assign head_pred = fifo_pred[head];
    assign pop       = bus.i_resolve_valid & ~empty;
    assign actual    = bus.i_resolve_taken ? bus.i_resolve_target : head_pc + STEP;
    assign flush_now = pop & (actual != head_pred);
    assign next_pc   = bus.i_inject ? bus.i_inject_addr : pc + STEP;

    // A mispredict must win over a same-cycle fetch, so it also masks fire.
    assign fire = ~reset & bus.enable & ~bus.i_stall & ~full & ~flush_now;

    assign bus.o_pm_pc            = pc;
    assign bus.o_fetch_valid      = fire;
    assign bus.o_fetch_pred_next  = next_pc;
    assign bus.o_fetch_predicted  = bus.i_inject;
    assign bus.o_flush            = flush_q;
    assign bus.o_resolve_err      = err_q;
    assign bus.o_pending          = count;
    assign bus.o_mispredict_count = mispredicts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            flush_q     <= 1'b0;
            err_q       <= 1'b0;
            mispredicts <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_pred[i] <= '0;
            end
        end else begin
            flush_q <= flush_now;
            err_q   <= bus.i_resolve_valid & empty;
            if (flush_now) begin
                // Every younger entry is on the wrong path, so the whole FIFO is dropped.
                pc    <= actual;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                if (mispredicts != '1) begin
                    mispredicts <= mispredicts + 32'd1;
                end
            end else begin
                if (fire) begin
                    pc              <= next_pc;
                    fifo_pc[tail]   <= pc;
                    fifo_pred[tail] <= next_pc;
                    tail            <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (fire && !pop) begin
                    count <= count + 1'b1;
                end else if (!fire && pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/riscv_fetch_pc_sequencer.md
# riscv_fetch_pc_sequencer

- Fetch-side PC generator at the program-memory end of the next-strategy interface.
- Presents the current fetch PC to the jump predictor and takes its inject/inject_addr answer in the same cycle to pick the next PC.
- Records every fetched instruction's predicted successor in an in-order tracking FIFO.
- Checks the FIFO against branch resolutions from execute; on a mismatch it redirects the PC and flushes.

## Interface
Parameters:
- ADDR_WIDTH, 64, width of all PCs and targets
- RESET_PC, 0, fetch PC after reset
- DEPTH, 4, tracking FIFO entries; power of two, ≥2
- INSTR_BYTES, 4, sequential PC increment

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  global advance enable
- i_stall  in  1  downstream stall; freezes fetch
- o_pm_pc  out  ADDR_WIDTH  current fetch PC, to predictor and program memory
- i_inject  in  1  predictor: redirect next PC
- i_inject_addr  in  ADDR_WIDTH  predictor target
- o_fetch_valid  out  1  instruction at o_pm_pc is fetched this cycle
- o_fetch_pred_next  out  ADDR_WIDTH  PC chosen as successor of o_pm_pc
- o_fetch_predicted  out  1  copy of i_inject for the fetched instruction
- i_resolve_valid  in  1  execute resolved the oldest outstanding instruction
- i_resolve_taken  in  1  actual control transfer taken
- i_resolve_target  in  ADDR_WIDTH  actual target when taken
- o_flush  out  1  one-cycle pulse: mispredict, younger instructions invalid
- o_resolve_err  out  1  one-cycle pulse: resolve with empty FIFO
- o_pending  out  $clog2(DEPTH)+1  outstanding entries
- o_mispredict_count  out  32  saturating mispredict counter

## Operation
- fire = enable & ~i_stall & ~full & ~flush_now.
- fire is driven on o_fetch_valid.
- next = i_inject ? i_inject_addr : o_pm_pc + INSTR_BYTES, computed modulo 2^ADDR_WIDTH with wrap allowed.
- On fire:
  - o_pm_pc ← next.
  - Push {pc, next} to the FIFO.
- On i_resolve_valid with the FIFO non-empty:
  - Pop the head.
  - actual = i_resolve_taken ? i_resolve_target : head.pc + INSTR_BYTES.
  - If actual ≠ head.pred_next, flush_now = 1 (combinational).
- On flush_now:
  - o_pm_pc ← actual.
  - FIFO cleared: head, tail and count go to 0, so all younger entries are dropped.
  - Any same-cycle push is discarded.
  - o_flush = 1 next cycle (registered pulse).
  - o_mispredict_count increments, saturating at 0xFFFFFFFF.
- Resolve with the FIFO empty: no pop, no flush; o_resolve_err pulses the next cycle.
- Push and pop in the same cycle without a flush: count unchanged, both pointers advance modulo DEPTH.
- full = (count == DEPTH).
  - While full, fire is 0 and o_pm_pc holds.
  - A pop in that cycle frees one slot for the next cycle; there is no same-cycle bypass.
- enable = 0 or i_stall = 1 blocks fetch only. Resolution and flush still act; a flush while stalled still redirects o_pm_pc.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any pending flush or error pulse is cancelled.

## Timing
- Reset values:
  - o_pm_pc = RESET_PC
  - o_pending = 0
  - o_flush = 0
  - o_resolve_err = 0
  - o_mispredict_count = 0
  - o_fetch_valid = 0 while reset is asserted
- o_fetch_valid, o_fetch_pred_next and o_fetch_predicted are combinational from o_pm_pc, the predictor inputs and the resolve inputs.
- The predictor sees o_pm_pc and answers in the same cycle.
- PC update latency is one cycle: the new o_pm_pc is visible after the edge where fire or flush_now is high.
- o_flush and o_resolve_err are registered and appear exactly one cycle after the causing resolve. The PC is already redirected in that same cycle.
- Sustained throughput is one fetch per cycle while the FIFO is not full.

## Test plan
- Reset, then enable=1, no inject, no resolve:
  - o_pm_pc steps 0,4,8,12.
  - Fetch stops at 12 with o_pending=4 (full, DEPTH=4) and o_pm_pc holds 16.
- Bench asserts i_inject with addr 44 whenever o_pm_pc==20, starting from RESET_PC=16:
  - sequence 16,20,44,48.
  - entry for 20 records pred_next=44 and o_fetch_predicted=1.
- Correct prediction: with the fetches above, resolve 16 not-taken, then 20 taken→44:
  - no o_flush.
  - o_pending decrements once per resolve.
- Mispredict: resolve entry 20 with taken=0:
  - PC becomes 24 at the next edge.
  - o_flush pulses for one cycle, o_pending=0, o_mispredict_count=1.
  - a push in the resolve cycle is dropped.
- Full FIFO plus simultaneous resolve:
  - correct resolve: o_pending stays at 3 after the edge, and fetch resumes the cycle after.
  - mispredicting resolve with i_stall=1: PC redirects anyway.
- Resolve with empty FIFO: o_resolve_err pulses once; PC and count unchanged. Assert reset mid-stream: all outputs return to reset values without a clock edge.
